image_bram_writer: RTL

- Streaming writer that fills the palette-index image BRAM that the sprite renderer reads.
- Accepts a raster-order stream of 8-bit palette indices with a start-of-frame marker and valid/ready handshake.
- Generates the linear BRAM write address (row*WIDTH + col), write data and write enable.
- Sits between a pixel source (UART/camera loader) and the write side of the image RAM.

---
 rtl/image_bram_writer_if.sv | 34 +++
 rtl/image_bram_writer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/image_bram_writer_if.sv
// rtl/image_bram_writer_if.sv - pixel stream in / BRAM write port out bundle for image_bram_writer
interface image_bram_writer_if #(
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int DATA_WIDTH = 8
);
  localparam int ADDR_WIDTH = $clog2(WIDTH * HEIGHT);

  // Pixel source side
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  sof_in;
  logic                  ready_out;

  // BRAM write side and status
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  we_out;
  logic                  busy_out;
  logic                  frame_done_out;
  logic                  error_out;

  // Pixel source / bench view
  modport master (
    output data_in, valid_in, sof_in,
    input  ready_out, addr_out, data_out, we_out, busy_out, frame_done_out, error_out
  );

  // Writer view
  modport slave (
    input  data_in, valid_in, sof_in,
    output ready_out, addr_out, data_out, we_out, busy_out, frame_done_out, error_out
  );
endinterface

// File: rtl/image_bram_writer.sv
// rtl/image_bram_writer.sv - raster pixel stream to linear palette-index BRAM writer
module image_bram_writer #(
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int DATA_WIDTH = 8
) (
  input logic                pixel_clk_in,
  input logic                rst_in,
  image_bram_writer_if.slave bus
);

  localparam int COL_W  = $clog2(WIDTH);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Position of the next pixel to be written; r_addr_cnt tracks row*WIDTH+col
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_W-1:0]     r_addr_cnt;

  // Registered BRAM write port and status
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we;
  logic                  r_frame_done;
  logic                  r_error;

  logic w_ready;
  logic w_accept;
  logic w_sof_accept;
  logic w_pix_accept;
  logic w_last;

  // DONE is the only cycle in which the source is back-pressured
  assign w_ready      = (r_state != S_DONE);
  assign w_accept     = bus.valid_in && w_ready;
  // A sof restarts the frame from any accepting state, including mid-frame
  assign w_sof_accept = w_accept && bus.sof_in;
  // Non-sof pixels only count inside a frame; in IDLE they are dropped
  assign w_pix_accept = w_accept && !bus.sof_in && (r_state == S_WRITE);
  assign w_last       = w_pix_accept && (r_col == COL_LAST) && (r_row == ROW_LAST);

  // State register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sof_accept) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Raster position counters; cleared after the last pixel so IDLE never shows a stale position
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr_cnt <= '0;
    end else if (w_sof_accept) begin
      r_col      <= COL_W'(1);
      r_row      <= '0;
      r_addr_cnt <= ADDR_W'(1);
    end else if (w_last) begin
      r_col      <= '0;
      r_row      <= '0;
      r_addr_cnt <= '0;
    end else if (w_pix_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
    end
  end

  // BRAM write port: one cycle after accept; address/data hold when no write
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_we         <= w_sof_accept || w_pix_accept;
      r_frame_done <= w_last;
      if (w_sof_accept) begin
        r_addr <= '0;
        r_data <= bus.data_in;
      end else if (w_pix_accept) begin
        r_addr <= r_addr_cnt;
        r_data <= bus.data_in;
      end
    end
  end

  // Sticky restart flag: set by a sof inside a frame, cleared by a sof that opens a fresh frame
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_error <= 1'b0;
    end else if (w_sof_accept) begin
      r_error <= (r_state == S_WRITE);
    end
  end

  assign bus.ready_out      = w_ready;
  assign bus.busy_out       = (r_state != S_IDLE);
  assign bus.addr_out       = r_addr;
  assign bus.data_out       = r_data;
  assign bus.we_out         = r_we;
  assign bus.frame_done_out = r_frame_done;
  assign bus.error_out      = r_error;

endmodule
